// File: rtl/mul_mdc_ctrl_pkg.sv
// Shared types and constants for the mul_mdc job sequencer: descriptor layout,
// controller states and the element-target helper.
package mul_mdc_ctrl_package;

    localparam int CNT_LEN = 4096;
    localparam int LEN_W   = $clog2(CNT_LEN);
    localparam int NOUT_W  = 16;
    localparam int TGT_W   = 29;

    typedef struct packed {
        logic              simple_mul;
        logic [4:0]        shift;
        logic [LEN_W-1:0]  len;
        logic [NOUT_W-1:0] nout;
    } mul_mdc_desc_t;

    localparam int DESC_W = $bits(mul_mdc_desc_t);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        CLR  = 3'd2,
        RUN  = 3'd3,
        DONE = 3'd4
    } mul_mdc_ctrl_state_t;

    // Number of a/b elements the engine consumes for one job; 16x13 bits fits in 29.
    function automatic logic [TGT_W-1:0] ab_target(input mul_mdc_desc_t d);
        logic [TGT_W-1:0] n;
        logic [TGT_W-1:0] l;
        n = TGT_W'(d.nout);
        l = TGT_W'(d.len) + TGT_W'(1);
        ab_target = d.simple_mul ? n : n * l;
    endfunction

endpackage

// File: rtl/mul_mdc_ctrl_desc_fifo.sv
// Synchronous descriptor FIFO with full/empty flags and a registered head entry.
// A push is also accepted while full when a pop happens in the same cycle.
module mul_mdc_desc_fifo
    import mul_mdc_ctrl_package::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DESC_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DESC_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DESC_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_next;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = rd_en & ~empty;
    assign do_push = wr_en & (~full | do_pop);
    assign rd_next = do_pop ? rd_ptr + AW'(1) : rd_ptr;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_next;
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            // Bypass the write when it lands in the slot that becomes the new head.
            head <= (do_push && (wr_ptr == rd_next)) ? wr_data : mem[rd_next];
        end
    end

endmodule

// File: rtl/mul_mdc_ctrl.sv
// Job sequencer for the mul_mdc engine: queues descriptors, configures and clears
// the engine, gates a/b and d streams per job. Optional perf counters: MUL_MDC_CTRL_PERF_EN.
module mul_mdc_ctrl
    import mul_mdc_ctrl_package::*;
#(
    parameter int QUEUE_DEPTH = 4
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              desc_valid,
    output logic              desc_ready,
    input  logic              desc_simple_mul,
    input  logic [4:0]        desc_shift,
    input  logic [LEN_W-1:0]  desc_len,
    input  logic [NOUT_W-1:0] desc_nout,
    input  logic              abort,
    input  logic              src_ab_valid,
    output logic              src_ab_ready,
    output logic              eng_ab_valid,
    input  logic              eng_ab_ready,
    input  logic              eng_d_valid,
    input  logic              sink_d_ready,
    output logic              eng_d_ready,
    output logic              reg_simple_mul,
    output logic [4:0]        reg_shift,
    output logic [LEN_W-1:0]  reg_len,
    output logic              eng_rst_n,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              err,
    output logic [15:0]       jobs_done,
`ifdef MUL_MDC_CTRL_PERF_EN
    output logic [31:0]       stall_cycles,
    output logic [31:0]       job_cycles,
`endif
    output logic [2:0]        dbg_state
);

    // Streams use valid/ready: a transfer happens on a clock edge where both are high.
    mul_mdc_ctrl_state_t state;
    mul_mdc_ctrl_state_t state_nxt;
    mul_mdc_desc_t       push_desc;
    mul_mdc_desc_t       head_desc;
    logic [DESC_W-1:0]   head_bits;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic                push_ok;
    logic [NOUT_W-1:0]   nout_q;
    logic [NOUT_W-1:0]   d_cnt;
    logic [TGT_W-1:0]    ab_tgt;
    logic [TGT_W-1:0]    ab_cnt;
    logic                ab_open;
    logic                ab_hs;
    logic                d_hs;
    logic                last_d;
    logic                abort_q;

    assign push_desc  = {desc_simple_mul, desc_shift, desc_len, desc_nout};
    assign head_desc  = mul_mdc_desc_t'(head_bits);
    assign fifo_pop   = ((state == IDLE) || (state == DONE)) && !fifo_empty;
    assign desc_ready = ~fifo_full | fifo_pop;
    assign push_ok    = desc_valid & desc_ready & (desc_nout != '0);
    assign ab_open    = (ab_cnt < ab_tgt);
    assign last_d     = d_hs && (d_cnt == nout_q - NOUT_W'(1));

    mul_mdc_desc_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (ap_clk),
        .rst     (ap_rst),
        .wr_en   (push_ok),
        .wr_data (push_desc),
        .rd_en   (fifo_pop),
        .head    (head_bits),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_nxt    = state;
        eng_ab_valid = 1'b0;
        src_ab_ready = 1'b0;
        eng_d_ready  = 1'b0;
        ab_hs        = 1'b0;
        d_hs         = 1'b0;
        case (state)
            IDLE: if (!fifo_empty) state_nxt = LOAD;
            LOAD: state_nxt = abort ? DONE : CLR;
            CLR:  state_nxt = abort ? DONE : RUN;
            RUN: begin
                eng_ab_valid = src_ab_valid & ab_open;
                src_ab_ready = eng_ab_ready & ab_open;
                eng_d_ready  = sink_d_ready;
                ab_hs        = eng_ab_valid & eng_ab_ready;
                d_hs         = eng_d_valid & sink_d_ready;
                if (last_d || abort) state_nxt = DONE;
            end
            DONE:    state_nxt = fifo_empty ? IDLE : LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state          <= IDLE;
            reg_simple_mul <= 1'b0;
            reg_shift      <= '0;
            reg_len        <= '0;
            nout_q         <= '0;
            ab_tgt         <= '0;
            ab_cnt         <= '0;
            d_cnt          <= '0;
            abort_q        <= 1'b0;
            eng_rst_n      <= 1'b1;
            err            <= 1'b0;
            jobs_done      <= '0;
        end else begin
            state     <= state_nxt;
            eng_rst_n <= (state_nxt != LOAD);
            if (desc_valid && desc_ready && (desc_nout == '0)) begin
                err <= 1'b1;
            end
            if (fifo_pop) begin
                reg_simple_mul <= head_desc.simple_mul;
                reg_shift      <= head_desc.shift;
                reg_len        <= head_desc.len;
                nout_q         <= head_desc.nout;
                ab_tgt         <= ab_target(head_desc);
                ab_cnt         <= '0;
                d_cnt          <= '0;
                abort_q        <= 1'b0;
            end else begin
                if (ab_hs) ab_cnt <= ab_cnt + TGT_W'(1);
                if (d_hs)  d_cnt  <= d_cnt + NOUT_W'(1);
                // Completion beats a simultaneous abort.
                if ((state != DONE) && (state_nxt == DONE)) abort_q <= ~last_d;
            end
            if ((state != DONE) && (state_nxt == DONE)) begin
                jobs_done <= jobs_done + 16'd1;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign aborted   = (state == DONE) & abort_q;
    assign dbg_state = state;

`ifdef MUL_MDC_CTRL_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] job_q;

    // job_q starts at 1 so the value seen during DONE already includes the DONE cycle.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            stall_q <= '0;
            job_q   <= '0;
        end else if (fifo_pop) begin
            stall_q <= '0;
            job_q   <= 32'd1;
        end else begin
            if ((state == RUN) && eng_d_valid && !sink_d_ready && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (((state == LOAD) || (state == CLR) || (state == RUN)) && (job_q != '1)) begin
                job_q <= job_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign job_cycles   = job_q;
`endif

endmodule

// File: tb/tb_mul_mdc_ctrl.sv
// Directed bench for mul_mdc_ctrl: table of jobs plus hand-written sequences for
// queue-full, abort, error, reset and (when enabled) perf-counter corners.
module tb_mul_mdc_ctrl;
    import mul_mdc_ctrl_package::*;

    logic              ap_clk = 1'b0;
    logic              ap_rst;
    logic              desc_valid;
    logic              desc_ready;
    logic              desc_simple_mul;
    logic [4:0]        desc_shift;
    logic [LEN_W-1:0]  desc_len;
    logic [NOUT_W-1:0] desc_nout;
    logic              abort;
    logic              src_ab_valid;
    logic              src_ab_ready;
    logic              eng_ab_valid;
    logic              eng_ab_ready;
    logic              eng_d_valid;
    logic              sink_d_ready;
    logic              eng_d_ready;
    logic              reg_simple_mul;
    logic [4:0]        reg_shift;
    logic [LEN_W-1:0]  reg_len;
    logic              eng_rst_n;
    logic              busy;
    logic              done;
    logic              aborted;
    logic              err;
    logic [15:0]       jobs_done;
    logic [2:0]        dbg_state;
`ifdef MUL_MDC_CTRL_PERF_EN
    logic [31:0]       stall_cycles;
    logic [31:0]       job_cycles;
`endif

    mul_mdc_ctrl #(.QUEUE_DEPTH(4)) dut (
        .ap_clk          (ap_clk),
        .ap_rst          (ap_rst),
        .desc_valid      (desc_valid),
        .desc_ready      (desc_ready),
        .desc_simple_mul (desc_simple_mul),
        .desc_shift      (desc_shift),
        .desc_len        (desc_len),
        .desc_nout       (desc_nout),
        .abort           (abort),
        .src_ab_valid    (src_ab_valid),
        .src_ab_ready    (src_ab_ready),
        .eng_ab_valid    (eng_ab_valid),
        .eng_ab_ready    (eng_ab_ready),
        .eng_d_valid     (eng_d_valid),
        .sink_d_ready    (sink_d_ready),
        .eng_d_ready     (eng_d_ready),
        .reg_simple_mul  (reg_simple_mul),
        .reg_shift       (reg_shift),
        .reg_len         (reg_len),
        .eng_rst_n       (eng_rst_n),
        .busy            (busy),
        .done            (done),
        .aborted         (aborted),
        .err             (err),
        .jobs_done       (jobs_done),
`ifdef MUL_MDC_CTRL_PERF_EN
        .stall_cycles    (stall_cycles),
        .job_cycles      (job_cycles),
`endif
        .dbg_state       (dbg_state)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic        sm;
        logic [4:0]  sh;
        logic [11:0] len;
        logic [15:0] nout;
        int          offer;
        int          exp_fwd;
    } vec_t;

    vec_t        vecs[5];
    vec_t        qv[5];
    logic [31:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          njobs    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic push(input logic sm, input logic [4:0] sh, input logic [11:0] len,
                        input logic [15:0] nout);
        desc_valid = 1'b1;
        desc_simple_mul = sm;
        desc_shift = sh;
        desc_len = len;
        desc_nout = nout;
        #1;
        check("push_desc_ready", desc_ready, 1);
        if (nout != 16'd0) exp_q.push_back({14'd0, sm, sh, len});
        tick();
        desc_valid = 1'b0;
    endtask

    task automatic check_load();
        logic [31:0] e;
        check("load_busy", busy, 1);
        check("load_eng_rst_n", eng_rst_n, 0);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL load_cfg actual=job_started expected=no_pending_job");
        end else begin
            e = exp_q.pop_front();
            check("load_cfg", {14'd0, reg_simple_mul, reg_shift, reg_len}, e);
        end
    endtask

    // Runs one job from IDLE-with-queued-descriptor (or LOAD when immediate) to after DONE.
    task automatic run_job(input vec_t v, input bit immediate);
        int waitc;
        int fwd;
        int offered;
        int dcnt;
        int cyc;
        waitc = 0;
        while (!busy && waitc < 10) begin
            tick();
            waitc++;
        end
        if (immediate) check("gap_load_follows_done", waitc, 0);
        check_load();
        src_ab_valid = 1'b1;
        eng_ab_ready = 1'b1;
        #1;
        check("gate_load", {eng_ab_valid, src_ab_ready, eng_d_ready}, 0);
        tick();
        check("eng_rst_n_clr", eng_rst_n, 1);
        check("gate_clr", {eng_ab_valid, src_ab_ready, eng_d_ready}, 0);
        tick();
        offered = 0;
        fwd = 0;
        for (int c = 0; c < v.offer + 6; c++) begin
            src_ab_valid = (offered < v.offer);
            eng_ab_ready = ((c % 4) != 3);
            #1;
            if (c == 0) check("first_run_ab_valid", eng_ab_valid, 1);
            if (eng_ab_valid && eng_ab_ready) fwd++;
            if (src_ab_valid && src_ab_ready) offered++;
            tick();
        end
        eng_ab_ready = 1'b1;
        #1;
        check("ab_forwarded", fwd, v.exp_fwd);
        check("ab_src_accepted", offered, v.exp_fwd);
        check("ab_stalled", {src_ab_valid, eng_ab_valid, src_ab_ready}, 3'b100);
        src_ab_valid = 1'b0;
        eng_d_valid = 1'b1;
        dcnt = 0;
        cyc = 0;
        while (dcnt < v.nout && cyc < 100) begin
            sink_d_ready = ((cyc % 3) != 1);
            #1;
            check("d_ready_follows_sink", eng_d_ready, sink_d_ready);
            check("no_early_done", done, 0);
            if (eng_d_valid && eng_d_ready) dcnt++;
            tick();
            cyc++;
        end
        eng_d_valid = 1'b0;
        sink_d_ready = 1'b0;
        njobs++;
        #1;
        check("d_results", dcnt, v.nout);
        check("done_pulse", {busy, done, aborted}, 3'b110);
        check("gate_done", {eng_ab_valid, src_ab_ready, eng_d_ready}, 0);
        tick();
        check("jobs_done", jobs_done, njobs);
    endtask

    // Reaches RUN for a freshly pushed descriptor, starting from IDLE.
    task automatic to_run();
        tick();
        check_load();
        tick();
        tick();
        check("state_run", dbg_state, RUN);
    endtask

    initial begin
        #2000000;
        checks++;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        vecs[0] = '{sm: 1'b1, sh: 5'd0,  len: 12'd0, nout: 16'd4, offer: 6,  exp_fwd: 4};
        vecs[1] = '{sm: 1'b0, sh: 5'd2,  len: 12'd3, nout: 16'd2, offer: 10, exp_fwd: 8};
        vecs[2] = '{sm: 1'b0, sh: 5'd0,  len: 12'd0, nout: 16'd3, offer: 5,  exp_fwd: 3};
        vecs[3] = '{sm: 1'b1, sh: 5'd7,  len: 12'd5, nout: 16'd1, offer: 3,  exp_fwd: 1};
        vecs[4] = '{sm: 1'b0, sh: 5'd31, len: 12'd1, nout: 16'd3, offer: 9,  exp_fwd: 6};
        qv[0]   = '{sm: 1'b1, sh: 5'd1,  len: 12'd0, nout: 16'd1, offer: 2,  exp_fwd: 1};
        qv[1]   = '{sm: 1'b0, sh: 5'd2,  len: 12'd1, nout: 16'd1, offer: 3,  exp_fwd: 2};
        qv[2]   = '{sm: 1'b1, sh: 5'd3,  len: 12'd9, nout: 16'd2, offer: 3,  exp_fwd: 2};
        qv[3]   = '{sm: 1'b0, sh: 5'd4,  len: 12'd0, nout: 16'd2, offer: 3,  exp_fwd: 2};
        qv[4]   = '{sm: 1'b1, sh: 5'd5,  len: 12'd2, nout: 16'd1, offer: 2,  exp_fwd: 1};

        ap_rst = 1'b1;
        desc_valid = 1'b0;
        desc_simple_mul = 1'b0;
        desc_shift = '0;
        desc_len = '0;
        desc_nout = '0;
        abort = 1'b0;
        src_ab_valid = 1'b0;
        eng_ab_ready = 1'b0;
        eng_d_valid = 1'b0;
        sink_d_ready = 1'b0;
        tick();
        tick();
        check("rst_cfg", {reg_simple_mul, reg_shift, reg_len}, 0);
        check("rst_flags", {eng_rst_n, busy, done, aborted, err}, 5'b10000);
        check("rst_jobs_done", jobs_done, 0);
        check("rst_gating", {eng_ab_valid, src_ab_ready, eng_d_ready}, 0);
        check("rst_state", dbg_state, IDLE);
        ap_rst = 1'b0;
        tick();
        check("idle_desc_ready", desc_ready, 1);

        // abort while idle has no effect
        abort = 1'b1;
        tick();
        tick();
        abort = 1'b0;
        check("idle_abort_ignored", {busy, done, aborted}, 0);
        check("idle_abort_jobs", jobs_done, 0);

        for (int i = 0; i < 5; i++) begin
            push(vecs[i].sm, vecs[i].sh, vecs[i].len, vecs[i].nout);
            run_job(vecs[i], 1'b0);
        end

        // Queue fill: job A holds RUN while four descriptors fill the FIFO.
        push(1'b1, 5'd0, 12'd0, 16'd1);
        to_run();
        for (int i = 0; i < 4; i++) push(qv[i].sm, qv[i].sh, qv[i].len, qv[i].nout);
        desc_valid = 1'b1;
        desc_simple_mul = qv[4].sm;
        desc_shift = qv[4].sh;
        desc_len = qv[4].len;
        desc_nout = qv[4].nout;
        #1;
        check("fifo_full_blocks", desc_ready, 0);
        tick();
        check("fifo_full_holds", desc_ready, 0);
        eng_d_valid = 1'b1;
        sink_d_ready = 1'b1;
        tick();
        eng_d_valid = 1'b0;
        sink_d_ready = 1'b0;
        njobs++;
        #1;
        check("fill_a_done", {done, aborted}, 2'b10);
        check("pop_frees_slot", desc_ready, 1);
        exp_q.push_back({14'd0, qv[4].sm, qv[4].sh, qv[4].len});
        tick();
        desc_valid = 1'b0;
        for (int i = 0; i < 5; i++) run_job(qv[i], 1'b1);
        check("fifo_drained_idle", {busy, dbg_state}, {1'b0, 3'(IDLE)});

        // Abort after 2 of 8 elements, next queued job runs normally.
        push(1'b0, 5'd6, 12'd3, 16'd2);
        push(1'b1, 5'd8, 12'd0, 16'd2);
        check_load();
        tick();
        tick();
        src_ab_valid = 1'b1;
        eng_ab_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("abort_job_ab", eng_ab_valid, 1);
            tick();
        end
        src_ab_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        src_ab_valid = 1'b1;
        njobs++;
        #1;
        check("abort_done", {done, aborted}, 2'b11);
        check("abort_gating", {eng_ab_valid, src_ab_ready}, 0);
        tick();
        src_ab_valid = 1'b0;
        run_job('{sm: 1'b1, sh: 5'd8, len: 12'd0, nout: 16'd2, offer: 4, exp_fwd: 2}, 1'b1);

        // Zero-length descriptor is dropped and flags err.
        push(1'b1, 5'd0, 12'd0, 16'd0);
        check("err_set", err, 1);
        tick();
        tick();
        check("err_stays_idle", {busy, dbg_state}, {1'b0, 3'(IDLE)});
        check("err_no_job", jobs_done, njobs);

        // Abort together with final d: completion wins.
        push(1'b1, 5'd0, 12'd0, 16'd1);
        to_run();
        eng_d_valid = 1'b1;
        sink_d_ready = 1'b1;
        abort = 1'b1;
        tick();
        eng_d_valid = 1'b0;
        sink_d_ready = 1'b0;
        abort = 1'b0;
        njobs++;
        #1;
        check("abort_vs_last_d", {done, aborted}, 2'b10);
        tick();
        check("abort_vs_last_d_jobs", jobs_done, njobs);
        check("err_sticky", err, 1);

`ifdef MUL_MDC_CTRL_PERF_EN
        push(1'b1, 5'd0, 12'd0, 16'd1);
        to_run();
        eng_d_valid = 1'b1;
        sink_d_ready = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        sink_d_ready = 1'b1;
        tick();
        eng_d_valid = 1'b0;
        sink_d_ready = 1'b0;
        njobs++;
        #1;
        check("perf_done", done, 1);
        check("perf_stall_cycles", stall_cycles, 5);
        check("perf_job_cycles", job_cycles, 9);
        tick();
        check("perf_hold", stall_cycles, 5);
`endif

        // Synchronous reset in the middle of RUN.
        push(1'b0, 5'd9, 12'd7, 16'd3);
        to_run();
        src_ab_valid = 1'b1;
        eng_ab_ready = 1'b1;
        tick();
        tick();
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        src_ab_valid = 1'b0;
        #1;
        check("mid_rst_cfg", {reg_simple_mul, reg_shift, reg_len}, 0);
        check("mid_rst_flags", {eng_rst_n, busy, done, aborted, err}, 5'b10000);
        check("mid_rst_jobs", jobs_done, 0);
        check("mid_rst_gating", {eng_ab_valid, src_ab_ready, eng_d_ready}, 0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("mid_rst_no_done", {busy, done}, 0);
        end
        check("exp_q_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
